// File: rtl/axi_cdc_ctrl_pkg.sv
// Shared types for the AXI CDC drain/isolate controller.
package axi_cdc_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      DRAIN    = 2'd1,
      ISOLATED = 2'd2
   } drain_state_e;

endpackage

// File: rtl/axi_txn_counter.sv
// Outstanding-transaction counter: saturates at MAX, flags a decrement at zero.
module axi_txn_counter #(
   parameter int unsigned MAX = 8,
   localparam int unsigned CntW = $clog2(MAX + 1)
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            inc_i,
   input  logic            dec_i,
   output logic [CntW-1:0] cnt_o,
   output logic            full_o,
   output logic            empty_o,
   output logic            underflow_o
);

   localparam logic [CntW-1:0] MaxCnt = CntW'(MAX);

   logic [CntW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d       = cnt_q;
      underflow_o = 1'b0;
      if (inc_i && !dec_i) begin
         if (cnt_q != MaxCnt) cnt_d = cnt_q + 1'b1;
      end else if (dec_i && !inc_i) begin
         if (cnt_q == '0) underflow_o = 1'b1;
         else             cnt_d       = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

   assign cnt_o   = cnt_q;
   assign full_o  = (cnt_q == MaxCnt);
   assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/axi_cdc_drain_ctrl.sv
// Source-side AXI CDC controller: limits outstanding AW/AR transactions and
// drains/isolates the crossing on request. Only AW/AR handshakes are gated.
module axi_cdc_drain_ctrl
   import axi_cdc_ctrl_pkg::*;
#(
   parameter int unsigned MAX_W_TXNS = 8,
   parameter int unsigned MAX_R_TXNS = 8
) (
   input  logic                                src_clk_i,
   input  logic                                src_rst_ni,
   input  logic                                isolate_req_i,
   output logic                                isolated_o,
   input  logic                                slv_aw_valid_i,
   output logic                                slv_aw_ready_o,
   output logic                                mst_aw_valid_o,
   input  logic                                mst_aw_ready_i,
   input  logic                                slv_ar_valid_i,
   output logic                                slv_ar_ready_o,
   output logic                                mst_ar_valid_o,
   input  logic                                mst_ar_ready_i,
   input  logic                                b_valid_i,
   input  logic                                b_ready_i,
   input  logic                                r_valid_i,
   input  logic                                r_ready_i,
   input  logic                                r_last_i,
   output logic [$clog2(MAX_W_TXNS+1)-1:0]     w_outstanding_o,
   output logic [$clog2(MAX_R_TXNS+1)-1:0]     r_outstanding_o,
   output logic                                cnt_err_o
);

   drain_state_e state_q, state_d;
   logic aw_hold_q, aw_hold_d;
   logic ar_hold_q, ar_hold_d;
   logic cnt_err_q, cnt_err_d;

   logic w_full, w_empty, w_uflow;
   logic r_full, r_empty, r_uflow;
   logic aw_pass, ar_pass;
   logic aw_hs, ar_hs, b_hs, r_hs, r_last_hs;

   // A held valid keeps passing regardless of state or limit so it is never retracted.
   assign aw_pass = ((state_q == RUN) && !w_full) || aw_hold_q;
   assign ar_pass = ((state_q == RUN) && !r_full) || ar_hold_q;

   assign mst_aw_valid_o = aw_pass & slv_aw_valid_i;
   assign slv_aw_ready_o = aw_pass & mst_aw_ready_i;
   assign mst_ar_valid_o = ar_pass & slv_ar_valid_i;
   assign slv_ar_ready_o = ar_pass & mst_ar_ready_i;

   assign aw_hs     = mst_aw_valid_o & mst_aw_ready_i;
   assign ar_hs     = mst_ar_valid_o & mst_ar_ready_i;
   assign b_hs      = b_valid_i & b_ready_i;
   assign r_hs      = r_valid_i & r_ready_i;
   assign r_last_hs = r_hs & r_last_i;

   axi_txn_counter #(.MAX(MAX_W_TXNS)) u_w_cnt (
      .clk_i       (src_clk_i),
      .rst_ni      (src_rst_ni),
      .inc_i       (aw_hs),
      .dec_i       (b_hs),
      .cnt_o       (w_outstanding_o),
      .full_o      (w_full),
      .empty_o     (w_empty),
      .underflow_o (w_uflow)
   );

   axi_txn_counter #(.MAX(MAX_R_TXNS)) u_r_cnt (
      .clk_i       (src_clk_i),
      .rst_ni      (src_rst_ni),
      .inc_i       (ar_hs),
      .dec_i       (r_last_hs),
      .cnt_o       (r_outstanding_o),
      .full_o      (r_full),
      .empty_o     (r_empty),
      .underflow_o (r_uflow)
   );

   always_comb begin
      aw_hold_d = (aw_hold_q | (mst_aw_valid_o & ~mst_aw_ready_i)) & ~aw_hs;
      ar_hold_d = (ar_hold_q | (mst_ar_valid_o & ~mst_ar_ready_i)) & ~ar_hs;
      cnt_err_d = cnt_err_q | w_uflow | r_uflow;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         RUN: if (isolate_req_i) state_d = DRAIN;
         DRAIN: begin
            if (!isolate_req_i) begin
               state_d = RUN;
            end else if (w_empty && r_empty && !aw_hold_q && !ar_hold_q &&
                         !(aw_hs || ar_hs || b_hs || r_hs)) begin
               state_d = ISOLATED;
            end
         end
         ISOLATED: if (!isolate_req_i) state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge src_clk_i or negedge src_rst_ni) begin
      if (!src_rst_ni) begin
         state_q   <= RUN;
         aw_hold_q <= 1'b0;
         ar_hold_q <= 1'b0;
         cnt_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         aw_hold_q <= aw_hold_d;
         ar_hold_q <= ar_hold_d;
         cnt_err_q <= cnt_err_d;
      end
   end

   assign isolated_o = (state_q == ISOLATED);
   assign cnt_err_o  = cnt_err_q;

endmodule

// File: tb/tb_axi_cdc_drain_ctrl.sv
// Self-checking bench for axi_cdc_drain_ctrl: directed scenarios plus random traffic vs. a reference model.
module tb_axi_cdc_drain_ctrl;

   localparam int MW = 2;
   localparam int MR = 3;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic iso, awv, awr, arv, arr, bv, br, rv, rr, rl;
   logic isolated, slv_aw_ready, mst_aw_valid, slv_ar_ready, mst_ar_valid, cnt_err;
   logic [1:0] w_out, r_out;

   axi_cdc_drain_ctrl #(.MAX_W_TXNS(MW), .MAX_R_TXNS(MR)) dut (
      .src_clk_i       (clk),
      .src_rst_ni      (rst_n),
      .isolate_req_i   (iso),
      .isolated_o      (isolated),
      .slv_aw_valid_i  (awv),
      .slv_aw_ready_o  (slv_aw_ready),
      .mst_aw_valid_o  (mst_aw_valid),
      .mst_aw_ready_i  (awr),
      .slv_ar_valid_i  (arv),
      .slv_ar_ready_o  (slv_ar_ready),
      .mst_ar_valid_o  (mst_ar_valid),
      .mst_ar_ready_i  (arr),
      .b_valid_i       (bv),
      .b_ready_i       (br),
      .r_valid_i       (rv),
      .r_ready_i       (rr),
      .r_last_i        (rl),
      .w_outstanding_o (w_out),
      .r_outstanding_o (r_out),
      .cnt_err_o       (cnt_err)
   );

   int checks = 0;
   int failures = 0;

   // Reference model: 0 = running, 1 = draining, 2 = isolated.
   int m_mode;
   int m_w, m_r;
   bit m_awh, m_arh, m_err;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_mode = 0; m_w = 0; m_r = 0; m_awh = 0; m_arh = 0; m_err = 0;
   endtask

   task automatic idle_inputs();
      awv = 0; awr = 0; arv = 0; arr = 0; bv = 0; br = 0; rv = 0; rr = 0; rl = 0;
   endtask

   // Check all outputs against the model, then advance one clock.
   task automatic tick();
      bit paw, par, aw_hs, ar_hs, b_hs, rl_hs, any_hs, n_err;
      int nw, nr, nmode;
      #2;
      paw = (m_mode == 0 && m_w < MW) || m_awh;
      par = (m_mode == 0 && m_r < MR) || m_arh;
      chk("mst_aw_valid", mst_aw_valid, paw & awv);
      chk("slv_aw_ready", slv_aw_ready, paw & awr);
      chk("mst_ar_valid", mst_ar_valid, par & arv);
      chk("slv_ar_ready", slv_ar_ready, par & arr);
      chk("isolated", isolated, m_mode == 2);
      chk("w_outstanding", w_out, m_w);
      chk("r_outstanding", r_out, m_r);
      chk("cnt_err", cnt_err, m_err);
      aw_hs = paw & awv & awr;
      ar_hs = par & arv & arr;
      b_hs  = bv & br;
      rl_hs = rv & rr & rl;
      any_hs = aw_hs | ar_hs | b_hs | (rv & rr);
      n_err = m_err;
      nw = m_w + int'(aw_hs) - int'(b_hs);
      if (nw < 0) begin nw = 0; n_err = 1; end
      nr = m_r + int'(ar_hs) - int'(rl_hs);
      if (nr < 0) begin nr = 0; n_err = 1; end
      nmode = m_mode;
      if (m_mode == 0) nmode = iso ? 1 : 0;
      else if (!iso) nmode = 0;
      else if (m_mode == 1 && m_w == 0 && m_r == 0 && !m_awh && !m_arh && !any_hs) nmode = 2;
      @(posedge clk);
      m_mode = nmode; m_w = nw; m_r = nr; m_err = n_err;
      m_awh = paw & awv & ~awr;
      m_arh = par & arv & ~arr;
      #1;
   endtask

   initial begin
      rst_n = 1'b0; iso = 0; idle_inputs(); model_reset();
      #12;
      chk("reset_isolated", isolated, 0);
      chk("reset_w_out", w_out, 0);
      chk("reset_r_out", r_out, 0);
      chk("reset_err", cnt_err, 0);
      chk("reset_aw_valid", mst_aw_valid, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      tick();

      // Outstanding-write limit
      awv = 1; awr = 1;
      tick(); tick();
      #2; chk("limit_3rd_blocked", slv_aw_ready, 0);
      tick();
      bv = 1; br = 1;
      tick();
      bv = 0; br = 0;
      #2; chk("limit_3rd_accepted", slv_aw_ready, 1);
      tick();
      awv = 0; awr = 0;
      #2; chk("limit_w_out", w_out, 2);
      tick();
      bv = 1; br = 1; tick(); tick();
      bv = 0; br = 0; tick();

      // Idle isolate
      iso = 1; tick();
      awv = 1; arv = 1;
      #2; chk("idle_aw_blocked", mst_aw_valid, 0);
      chk("idle_ar_blocked", mst_ar_valid, 0);
      tick();
      #2; chk("idle_isolated_c2", isolated, 1);
      tick(); tick();
      awv = 0; arv = 0; iso = 0; tick();
      #2; chk("release_run", isolated, 0);
      tick();

      // Busy drain: one write, one read with four beats
      awv = 1; awr = 1; arv = 1; arr = 1; tick();
      idle_inputs(); iso = 1; tick();
      rv = 1; rr = 1;
      for (int i = 0; i < 3; i++) begin
         #2; chk("busy_beat_iso_low", isolated, 0);
         tick();
      end
      rl = 1; tick();
      rv = 0; rr = 0; rl = 0; bv = 1; br = 1; tick();
      bv = 0; br = 0;
      #2; chk("busy_n1_iso_low", isolated, 0);
      tick();
      #2; chk("busy_n2_iso_high", isolated, 1);
      tick();
      iso = 0; tick(); tick();

      // Hold: stalled AW stays presented through isolate
      awv = 1; awr = 0; tick();
      iso = 1;
      #2; chk("hold_valid_kept", mst_aw_valid, 1);
      tick(); tick();
      awr = 1; tick();
      awv = 0; awr = 0;
      #2; chk("hold_w_out", w_out, 1);
      tick(); tick(); tick();
      #2; chk("hold_wait_b", isolated, 0);
      bv = 1; br = 1; tick();
      bv = 0; br = 0; tick(); tick();
      #2; chk("hold_isolated", isolated, 1);
      iso = 0; tick(); tick();

      // Simultaneous AW and B, then underflow
      awv = 1; awr = 1; tick();
      bv = 1; br = 1; tick();
      awv = 0; awr = 0;
      #2; chk("simul_w_out", w_out, 1);
      tick();
      tick();
      bv = 0; br = 0;
      #2; chk("uflow_w_out", w_out, 0);
      chk("uflow_err", cnt_err, 1);
      tick(); tick();
      #2; chk("uflow_sticky", cnt_err, 1);

      // Abort drain
      awv = 1; awr = 1; tick();
      awv = 0; awr = 0; iso = 1; tick(); tick();
      iso = 0; tick();
      awv = 1; awr = 1;
      #2; chk("abort_resume", slv_aw_ready, 1);
      tick();
      idle_inputs(); bv = 1; br = 1; tick(); tick();
      bv = 0; br = 0; tick();

      // Reset mid-drain
      awv = 1; awr = 1; tick();
      awv = 0; awr = 0; iso = 1; tick(); tick();
      rst_n = 1'b0; iso = 0; idle_inputs(); model_reset();
      #2;
      chk("rst_mid_isolated", isolated, 0);
      chk("rst_mid_w_out", w_out, 0);
      chk("rst_mid_err", cnt_err, 0);
      chk("rst_mid_aw_valid", mst_aw_valid, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      tick();

      // Random traffic against the model
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(15) == 0) iso = ~iso;
         awv = m_awh ? 1'b1 : 1'($urandom_range(1));
         awr = 1'($urandom_range(1));
         arv = m_arh ? 1'b1 : 1'($urandom_range(1));
         arr = 1'($urandom_range(1));
         bv  = (m_w > 0 || $urandom_range(31) == 0) ? 1'($urandom_range(1)) : 1'b0;
         br  = 1'($urandom_range(1));
         rv  = (m_r > 0) ? 1'($urandom_range(1)) : 1'b0;
         rr  = 1'($urandom_range(1));
         rl  = 1'($urandom_range(1));
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
